// File: rtl/sc_hdlc_pkg.sv
// Shared definitions for the HDLC core's AXI4-Stream side.
// - SC_BYTE_W : default stream byte width
// - sc_state_e : receive FSM state encoding (IDLE/RECV/DONE)
package sc_hdlc_pkg;

  localparam int SC_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } sc_state_e;

endpackage

// File: rtl/sc_hdlc_v1_0_s_axis.sv
// AXI4-Stream byte slave feeding the HDLC TX FIFO.
// Software pulses AXISRdReq with a byte count in AXISRdNum; the block then
// accepts up to that many beats from the stream and writes each accepted byte
// directly into the FIFO in the same cycle. The transfer ends early on TLAST.
//
// Ports
//   S_AXIS_ACLK / S_AXIS_ARESETN : clock, async active-low reset
//   S_AXIS_TVALID/TDATA/TSTRB/TLAST/TREADY : upstream stream (TSTRB ignored)
//   AXISRdReq / AXISRdNum        : start pulse and byte count
//   AXISRdBusy / AXISRdDone      : in progress, one-cycle completion pulse
//   AXISRdCnt / AXISRdLast       : bytes accepted, transfer ended on TLAST
//   FIFOFull / FIFOAFull         : FIFO status (AFull informational only)
//   FIFOWrData / FIFOWrEn        : FIFO write port
module sc_hdlc_v1_0_s_axis
  import sc_hdlc_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = SC_BYTE_W,
  parameter int C_NUM_WIDTH          = 32
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESETN,
  input  logic                            S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                            S_AXIS_TSTRB,
  input  logic                            S_AXIS_TLAST,
  output logic                            S_AXIS_TREADY,
  input  logic                            AXISRdReq,
  input  logic [C_NUM_WIDTH-1:0]          AXISRdNum,
  output logic                            AXISRdBusy,
  output logic                            AXISRdDone,
  output logic [C_NUM_WIDTH-1:0]          AXISRdCnt,
  output logic                            AXISRdLast,
  input  logic                            FIFOFull,
  input  logic                            FIFOAFull,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] FIFOWrData,
  output logic                            FIFOWrEn
);

  localparam logic [C_NUM_WIDTH-1:0] ONE = {{(C_NUM_WIDTH-1){1'b0}}, 1'b1};

  sc_state_e              state_q, state_d;
  logic [C_NUM_WIDTH-1:0] num_r, num_d;
  logic [C_NUM_WIDTH-1:0] cnt_q, cnt_d;
  logic [C_NUM_WIDTH-1:0] cnt_inc;
  logic                   last_q, last_d;
  logic                   tready;
  logic                   hs;

  // Strobe is meaningless for a single-byte lane; FIFOAFull is advisory only.
  logic unused_inputs;
  assign unused_inputs = S_AXIS_TSTRB ^ FIFOAFull;

  // Ready comes only from registered state plus the FIFO's registered full
  // flag, so there is no combinational path from TVALID back to TREADY.
  // The cnt < num guard keeps ready low even if the FSM lingered in RECV.
  assign tready  = (state_q == ST_RECV) && !FIFOFull && (cnt_q < num_r);
  assign hs      = S_AXIS_TVALID && tready;
  assign cnt_inc = cnt_q + ONE;

  // Zero-latency write: the FIFO captures the byte on the handshake edge.
  // Data is masked so the write bus sits at zero when nothing is written.
  assign FIFOWrEn   = hs;
  assign FIFOWrData = hs ? S_AXIS_TDATA : '0;

  assign S_AXIS_TREADY = tready;
  assign AXISRdBusy    = (state_q == ST_RECV);
  assign AXISRdDone    = (state_q == ST_DONE);
  assign AXISRdCnt     = cnt_q;
  assign AXISRdLast    = last_q;

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q <= ST_IDLE;
      num_r   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_r   <= num_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_r;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        // Requests are only honoured here; RECV and DONE ignore them.
        if (AXISRdReq) begin
          num_d   = AXISRdNum;
          cnt_d   = '0;
          last_d  = 1'b0;
          state_d = (AXISRdNum == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        if (hs) begin
          cnt_d = cnt_inc;
          // Whichever comes first: requested count reached or TLAST seen.
          // cnt_inc cannot wrap because the transfer stops at num_r.
          if ((cnt_inc == num_r) || S_AXIS_TLAST) begin
            last_d  = S_AXIS_TLAST;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sc_hdlc_v1_0_s_axis.sv
module tb_sc_hdlc_v1_0_s_axis;

  logic        clk;
  logic        rst_n;
  logic        tvalid;
  logic [7:0]  tdata;
  logic        tstrb;
  logic        tlast;
  logic        tready;
  logic        req;
  logic [31:0] num;
  logic        busy;
  logic        done;
  logic [31:0] cnt;
  logic        last;
  logic        full;
  logic        afull;
  logic [7:0]  wdata;
  logic        wen;

  int errors = 0;
  int checks = 0;

  sc_hdlc_v1_0_s_axis #(.C_S_AXIS_TDATA_WIDTH(8), .C_NUM_WIDTH(32)) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .S_AXIS_TVALID  (tvalid),
    .S_AXIS_TDATA   (tdata),
    .S_AXIS_TSTRB   (tstrb),
    .S_AXIS_TLAST   (tlast),
    .S_AXIS_TREADY  (tready),
    .AXISRdReq      (req),
    .AXISRdNum      (num),
    .AXISRdBusy     (busy),
    .AXISRdDone     (done),
    .AXISRdCnt      (cnt),
    .AXISRdLast     (last),
    .FIFOFull       (full),
    .FIFOAFull      (afull),
    .FIFOWrData     (wdata),
    .FIFOWrEn       (wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One stimulus record: transfer setup plus the expected outcome.
  typedef struct {
    int num;          // requested byte count
    int tlast_beat;   // 1-based beat carrying TLAST, 0 = none
    int pause_every;  // drop TVALID for 3 cycles every N accepted beats, 0 = never
    int full_beat;    // raise FIFOFull once this many beats are accepted, 0 = never
    int full_len;     // cycles FIFOFull stays high
    int exp_writes;
    int exp_cnt;
    int exp_last;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one request to completion from a negedge; returns at a negedge.
  // Source offers byte value = beat index and keeps offering after Done.
  task automatic run_xfer(input vec_t v, input string tag);
    int   beat = 0, writes = 0, dones = 0, cyc = 0, post = -1;
    int   pause_left = 0, full_left = 0, paused_at = -1;
    int   viol = 0, data_err = 0, hs_err = 0;
    bit   fulled = 0, busy_fall_ok = 0;
    logic prev_busy = 1'b0;
    req = 1'b1; num = v.num; tvalid = 1'b0; tlast = 1'b0; full = 1'b0;
    @(negedge clk);
    req = 1'b0;
    while (cyc < 600 && post != 0) begin
      if (v.full_beat != 0 && beat == v.full_beat && !fulled) begin
        full_left = v.full_len; fulled = 1;
      end
      if (v.pause_every != 0 && beat != 0 && beat % v.pause_every == 0 && paused_at != beat) begin
        pause_left = 3; paused_at = beat;
      end
      full = (full_left > 0);
      if (full_left > 0) full_left--;
      tvalid = (pause_left == 0);
      if (pause_left > 0) pause_left--;
      tdata = beat[7:0];
      tlast = (v.tlast_beat != 0 && beat + 1 == v.tlast_beat);
      #1;
      if (full && (tready || wen)) viol++;
      if (wen !== (tvalid && tready)) hs_err++;
      if (wen) begin
        if (wdata !== writes[7:0]) data_err++;
        writes++;
      end
      if (tvalid && tready) beat++;
      if (done) begin
        dones++;
        if (prev_busy && !busy) busy_fall_ok = 1;
        post = 5;
      end
      if (post > 0) post--;
      prev_busy = busy;
      cyc++;
      @(negedge clk);
    end
    #1;
    chk({tag, " writes"}, writes, v.exp_writes);
    chk({tag, " done_pulses"}, dones, 1);
    chk({tag, " cnt"}, cnt, v.exp_cnt);
    chk({tag, " last"}, last, v.exp_last);
    chk({tag, " data_order"}, data_err, 0);
    chk({tag, " wren_vs_hs"}, hs_err, 0);
    chk({tag, " ready_while_full"}, viol, 0);
    chk({tag, " busy_falls_with_done"}, busy_fall_ok, 1);
    chk({tag, " tready_after"}, tready, 0);
    tvalid = 1'b0; tlast = 1'b0; full = 1'b0;
  endtask

  initial begin
    //          num tlast pause fullb flen  wr  cnt last
    vecs[0] = '{32,  32,    0,    0,   0,  32,  32, 1};
    vecs[1] = '{32,   0,   16,    0,   0,  32,  32, 0};
    vecs[2] = '{32,   0,    0,    8,   5,  32,  32, 0};
    vecs[3] = '{ 1,   0,    0,    0,   0,   1,   1, 0};
    vecs[4] = '{32,  10,    0,    0,   0,  10,  10, 1};
    vecs[5] = '{ 5,   5,    0,    2,   3,   5,   5, 1};
    vecs[6] = '{ 4,   0,    0,    0,   0,   4,   4, 0};

    rst_n = 1'b0; tvalid = 1'b1; tdata = 8'hA5; tstrb = 1'b1; tlast = 1'b0;
    req = 1'b0; num = '0; full = 1'b0; afull = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst tready", tready, 0);
    chk("rst wren", wen, 0);
    chk("rst wrdata", wdata, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst cnt", cnt, 0);
    chk("rst last", last, 0);
    @(negedge clk);
    rst_n = 1'b1; tvalid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

    // Zero-length request: straight to DONE, nothing accepted. Cnt/Last
    // from the previous transfer (5, 1) must be cleared.
    req = 1'b1; num = '0; tvalid = 1'b1; tdata = 8'h11;
    #1;
    chk("num0 busy_at_req", busy, 0);
    @(negedge clk);
    req = 1'b0;
    #1;
    chk("num0 done", done, 1);
    chk("num0 busy", busy, 0);
    chk("num0 tready", tready, 0);
    chk("num0 wren", wen, 0);
    chk("num0 cnt", cnt, 0);
    chk("num0 last", last, 0);
    @(negedge clk);
    #1;
    chk("num0 done_once", done, 0);
    chk("num0 tready_idle", tready, 0);
    tvalid = 1'b0;
    @(negedge clk);

    // Second request during a busy Num=4 transfer must be ignored.
    begin
      int b = 0, g = 0, dn = 0;
      req = 1'b1; num = 32'd4;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      req = 1'b1; num = 32'd100;
      #1;
      chk("rereq busy", busy, 1);
      @(negedge clk);
      req = 1'b0;
      while (g < 50 && dn == 0) begin
        tvalid = 1'b1; tdata = b[7:0]; tlast = 1'b0;
        #1;
        if (tvalid && tready) b++;
        if (done) dn = 1;
        g++;
        @(negedge clk);
      end
      tvalid = 1'b0;
      #1;
      chk("rereq done_seen", dn, 1);
      chk("rereq beats", b, 4);
      chk("rereq cnt", cnt, 4);
      @(negedge clk);
    end

    // Reset in the middle of a Num=32 transfer.
    begin
      int b = 0, g = 0;
      req = 1'b1; num = 32'd32;
      @(negedge clk);
      req = 1'b0;
      while (b < 5 && g < 50) begin
        tvalid = 1'b1; tdata = b[7:0]; tlast = 1'b0;
        #1;
        if (tvalid && tready) b++;
        g++;
        @(negedge clk);
      end
      chk("midrst beats", b, 5);
      tvalid = 1'b1; tdata = 8'h5A;
      #1;
      chk("midrst tready_before", tready, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst tready", tready, 0);
      chk("midrst wren", wen, 0);
      chk("midrst wrdata", wdata, 0);
      chk("midrst busy", busy, 0);
      chk("midrst cnt", cnt, 0);
      chk("midrst last", last, 0);
      chk("midrst done", done, 0);
      @(negedge clk);
      rst_n = 1'b1; tvalid = 1'b0;
      @(negedge clk);
      run_xfer(vecs[6], "post_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
